// File: rtl/instr_capture_pkg.sv
// instr_pkg: shared FSM state, field width and instruction word layout for instr_capture.
package instr_pkg;
    localparam int FIELD_W = 4;
    typedef enum logic [1:0] {IDLE, ARM, OFFER, RELEASE} capture_state_t;
    // codop is the most significant nibble, so the synchronised switch bus maps straight onto it
    typedef struct packed {
        logic [FIELD_W-1:0] codop;
        logic [FIELD_W-1:0] addA;
        logic [FIELD_W-1:0] addB_LMM;
        logic [FIELD_W-1:0] addC;
    } instr_t;
endpackage

// File: rtl/instr_capture_if.sv
// instr_capture_if: decoded instruction word plus valid/ready handshake.
// master (producer): codop, addA, addB_LMM, addC, instr_valid, busy out; instr_ready in.
// slave (consumer): the mirror image. With INSTR_CAPTURE_COUNT_EN, instr_count is carried too.
interface instr_capture_if;
    import instr_pkg::*;
    logic [FIELD_W-1:0] codop;
    logic [FIELD_W-1:0] addA;
    logic [FIELD_W-1:0] addB_LMM;
    logic [FIELD_W-1:0] addC;
    logic               instr_valid;
    logic               instr_ready;
    logic               busy;
`ifdef INSTR_CAPTURE_COUNT_EN
    logic [7:0]         instr_count;
`endif
    modport master (
        output codop, addA, addB_LMM, addC, instr_valid, busy,
`ifdef INSTR_CAPTURE_COUNT_EN
        output instr_count,
`endif
        input  instr_ready
    );
    modport slave (
        input  codop, addA, addB_LMM, addC, instr_valid, busy,
`ifdef INSTR_CAPTURE_COUNT_EN
        input  instr_count,
`endif
        output instr_ready
    );
endinterface

// File: rtl/instr_capture_key_debouncer.sv
// key_debouncer: 2-flop synchroniser plus stable-count debouncer for one active-low key.
// Ports: clk, rst (async, active-high), key_in (raw), key_sync (synchronised level),
// level (debounced level; 1 = released). Synchroniser and level reset to released.
module key_debouncer #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic key_in,
    output logic key_sync,
    output logic level
);
    logic [1:0]       sync_q, sync_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;

    always_comb begin
        sync_d  = {sync_q[0], key_in};
        level_d = level_q;
        cnt_d   = '0;
        // a disagreeing sample counts; the D-th consecutive one flips the level
        if (sync_q[1] != level_q) begin
            if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1))
                level_d = sync_q[1];
            else
                cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
        end else begin
            sync_q  <= sync_d;
            cnt_q   <= cnt_d;
            level_q <= level_d;
        end
    end

    assign key_sync = sync_q[1];
    assign level    = level_q;
endmodule

// File: rtl/instr_capture.sv
// instr_capture: debounced KEY[0] press latches the 16 switches into one instruction word,
// offered downstream with valid/ready; KEY[1] clears.
// Ports: CLOCK_50, reset (async, active-high), KEY[3:0] (active-low), sw3_0..sw15_12,
// bus (instr_capture_if.master). Optional INSTR_CAPTURE_COUNT_EN adds bus.instr_count.
module instr_capture
    import instr_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W           = 20
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [3:0] KEY,
    input  logic [3:0] sw3_0,
    input  logic [3:0] sw7_4,
    input  logic [3:0] sw11_8,
    input  logic [3:0] sw15_12,
    instr_capture_if.master bus
);
    logic           k0_sync, k0_level, unused_keys;
    logic [1:0]     clr_sync_q, clr_sync_d;
    logic [15:0]    sw_s1_q, sw_s1_d, sw_s2_q, sw_s2_d;
    capture_state_t state_q, state_d;
    instr_t         instr_q, instr_d;
`ifdef INSTR_CAPTURE_COUNT_EN
    logic [7:0]     count_q, count_d;
`endif

    assign unused_keys = ^KEY[3:2];

    key_debouncer #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES), .CNT_W(CNT_W)) u_ld (
        .clk(CLOCK_50), .rst(reset), .key_in(KEY[0]), .key_sync(k0_sync), .level(k0_level)
    );

    always_comb begin
        clr_sync_d = {clr_sync_q[0], KEY[1]};
        sw_s1_d    = {sw15_12, sw11_8, sw7_4, sw3_0};
        sw_s2_d    = sw_s1_q;
        state_d    = state_q;
        instr_d    = instr_q;
        case (state_q)
            IDLE:    state_d = k0_sync ? IDLE : ARM;
            ARM: begin
                // capture once the debounced level reports pressed while the key is still low
                state_d = k0_sync ? IDLE : (k0_level ? ARM : OFFER);
                instr_d = (!k0_sync && !k0_level) ? instr_t'(sw_s2_q) : instr_q;
            end
            OFFER:   state_d = bus.instr_ready ? RELEASE : OFFER;
            RELEASE: state_d = k0_level ? IDLE : RELEASE;
            default: state_d = IDLE;
        endcase
        if (!clr_sync_q[1]) begin
            state_d = IDLE;
            instr_d = '0;
        end
`ifdef INSTR_CAPTURE_COUNT_EN
        count_d = (state_q == OFFER && bus.instr_ready && clr_sync_q[1]) ? count_q + 8'd1 : count_q;
`endif
    end

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            clr_sync_q <= 2'b11;
            sw_s1_q    <= '0;
            sw_s2_q    <= '0;
            state_q    <= IDLE;
            instr_q    <= '0;
`ifdef INSTR_CAPTURE_COUNT_EN
            count_q    <= '0;
`endif
        end else begin
            clr_sync_q <= clr_sync_d;
            sw_s1_q    <= sw_s1_d;
            sw_s2_q    <= sw_s2_d;
            state_q    <= state_d;
            instr_q    <= instr_d;
`ifdef INSTR_CAPTURE_COUNT_EN
            count_q    <= count_d;
`endif
        end
    end

    assign bus.codop       = instr_q.codop;
    assign bus.addA        = instr_q.addA;
    assign bus.addB_LMM    = instr_q.addB_LMM;
    assign bus.addC        = instr_q.addC;
    assign bus.instr_valid = (state_q == OFFER);
    assign bus.busy        = (state_q != IDLE);
`ifdef INSTR_CAPTURE_COUNT_EN
    assign bus.instr_count = count_q;
`endif
endmodule

// File: tb/tb_instr_capture.sv
// tb_instr_capture: table-driven, hand-written and random presses for instr_capture.
module tb_instr_capture;
    localparam int D = 4;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  key;
    logic [15:0] sw;
    int          checks = 0;
    int          errors = 0;
    int          exp_count = 0;

    instr_capture_if bus();

    instr_capture #(.DEBOUNCE_CYCLES(D), .CNT_W(4)) dut (
        .CLOCK_50(clk), .reset(rst), .KEY(key),
        .sw3_0(sw[3:0]), .sw7_4(sw[7:4]), .sw11_8(sw[11:8]), .sw15_12(sw[15:12]),
        .bus(bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] sw;
        int          rd;
        int          hold;
        bit          early;
        logic [15:0] exp;
    } vec_t;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] fields();
        return {bus.codop, bus.addA, bus.addB_LMM, bus.addC};
    endfunction

    task automatic chk_count();
`ifdef INSTR_CAPTURE_COUNT_EN
        chk("instr_count", {24'd0, bus.instr_count}, exp_count % 256);
`endif
    endtask

    // One press: nb short bounces, a clean low until valid, rd cycles of ready low,
    // the key kept low for hold cycles after valid, then a full release.
    task automatic press(input logic [15:0] s, input int rd, input int hold, input bit early,
                         input int nb, input logic [15:0] exp);
        int k, held;
        sw = s;
        bus.instr_ready = early;
        for (int b = 0; b < nb; b++) begin
            key[0] = 1'b0;
            repeat ($urandom_range(1, D - 1)) begin tick(); chk("bounce_low_valid", {31'd0, bus.instr_valid}, 0); end
            key[0] = 1'b1;
            repeat ($urandom_range(1, D - 1)) begin tick(); chk("bounce_high_valid", {31'd0, bus.instr_valid}, 0); end
        end
        key[0] = 1'b0;
        k = 0;
        do begin tick(); k++; end while (!bus.instr_valid && k < D + 20);
        chk("capture_latency", k, D + 3);
        chk("captured_fields", {16'd0, fields()}, {16'd0, exp});
        held = 0;
        for (int i = 0; i <= rd; i++) begin
            bus.instr_ready = (i == rd);
            key[0] = (held < hold) ? 1'b0 : 1'b1;
            held++;
            sw = 16'($urandom);
            tick();
            if (i == rd) begin
                exp_count++;
                chk("valid_after_accept", {31'd0, bus.instr_valid}, 0);
            end else begin
                chk("valid_held", {31'd0, bus.instr_valid}, 1);
                chk("fields_frozen_offer", {16'd0, fields()}, {16'd0, exp});
            end
        end
        bus.instr_ready = 1'b0;
        while (held < hold) begin
            key[0] = 1'b0;
            sw = 16'($urandom);
            tick();
            held++;
            chk("no_recapture", {31'd0, bus.instr_valid}, 0);
            chk("busy_while_held", {31'd0, bus.busy}, 1);
            chk("fields_frozen_release", {16'd0, fields()}, {16'd0, exp});
        end
        key[0] = 1'b1;
        repeat (D + 4) begin tick(); chk("valid_after_release", {31'd0, bus.instr_valid}, 0); end
        chk("busy_idle", {31'd0, bus.busy}, 0);
        chk_count();
    endtask

    initial begin
        vec_t tbl[4];
        int   k;
        tbl[0] = '{16'hA5C3, 0, 0, 1'b1, 16'hA5C3};
        tbl[1] = '{16'h0000, 2, 0, 1'b0, 16'h0000};
        tbl[2] = '{16'hFFFF, 1, 3, 1'b0, 16'hFFFF};
        tbl[3] = '{16'h1234, 10, 50, 1'b0, 16'h1234};

        rst = 1'b1; key = 4'hF; sw = 16'h0; bus.instr_ready = 1'b0;
        tick(); tick();
        chk("reset_fields", {16'd0, fields()}, 0);
        chk("reset_valid", {31'd0, bus.instr_valid}, 0);
        chk("reset_busy", {31'd0, bus.busy}, 0);
        chk_count();
        rst = 1'b0;
        tick(); tick();

        for (int i = 0; i < 4; i++)
            press(tbl[i].sw, tbl[i].rd, tbl[i].hold, tbl[i].early, 0, tbl[i].exp);

        // bounce: low 3, high 1, then a clean final low
        sw = 16'h6B2D;
        key[0] = 1'b0;
        repeat (3) begin tick(); chk("bounce3_valid", {31'd0, bus.instr_valid}, 0); end
        key[0] = 1'b1;
        tick();
        chk("bounce_gap_valid", {31'd0, bus.instr_valid}, 0);
        press(16'h6B2D, 1, 0, 1'b0, 0, 16'h6B2D);

        // clear during OFFER with ready high in the cycle clear is seen
        sw = 16'h7E19;
        key[0] = 1'b0;
        k = 0;
        do begin tick(); k++; end while (!bus.instr_valid && k < D + 20);
        chk("clear_seq_latency", k, D + 3);
        key[0] = 1'b1;
        repeat (D + 6) begin
            sw = 16'($urandom);
            tick();
            chk("offer_wait_valid", {31'd0, bus.instr_valid}, 1);
            chk("offer_wait_fields", {16'd0, fields()}, 32'h7E19);
        end
        key[1] = 1'b0;
        tick(); tick();
        chk("clear_not_yet", {31'd0, bus.instr_valid}, 1);
        bus.instr_ready = 1'b1;
        tick();
        chk("clear_fields", {16'd0, fields()}, 0);
        chk("clear_valid", {31'd0, bus.instr_valid}, 0);
        chk("clear_busy", {31'd0, bus.busy}, 0);
        chk_count();
        key[1] = 1'b1;
        bus.instr_ready = 1'b0;
        repeat (4) begin tick(); chk("after_clear_valid", {31'd0, bus.instr_valid}, 0); end

        // randomized presses; the model word is the switch setting held through the press
        for (int i = 0; i < 20; i++) begin
            logic [15:0] s;
            s = 16'($urandom);
            press(s, $urandom_range(0, 5), $urandom_range(0, 8), 1'($urandom_range(0, 1)),
                  $urandom_range(0, 2), s);
        end

        // asynchronous reset while in ARM
        press(16'hC0DE, 0, 0, 1'b0, 0, 16'hC0DE);
        sw = 16'h9999;
        key[0] = 1'b0;
        repeat (4) tick();
        chk("arm_busy", {31'd0, bus.busy}, 1);
        rst = 1'b1;
        #1;
        chk("async_reset_busy", {31'd0, bus.busy}, 0);
        chk("async_reset_fields", {16'd0, fields()}, 0);
        chk("async_reset_valid", {31'd0, bus.instr_valid}, 0);
        exp_count = 0;
        chk_count();
        key[0] = 1'b1;
        tick(); tick();
        rst = 1'b0;
        repeat (D + 4) tick();
        press(16'h5A3C, 0, 0, 1'b1, 0, 16'h5A3C);

`ifdef INSTR_CAPTURE_COUNT_EN
        k = 256 - (exp_count % 256);
        for (int i = 0; i < k; i++) press(16'h1111, 0, 0, 1'b1, 0, 16'h1111);
        chk("count_wrap_zero", {24'd0, bus.instr_count}, 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
